rx_deserializer: RTL and testbench
==================================

RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
Parameters:
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 4, giving the output FIFO depth in words (power of two, at least 2).
Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port arst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_line, input, 2 bits: the serial symbol stream from the transmitter, synchronous to clk, one symbol per cycle.
REQ-005 The block SHALL have port out_data, output, 16 bits: the received data word at the FIFO head.
REQ-006 The block SHALL have port out_chan, output, 2 bits: the source channel (0..2) of out_data.
REQ-007 The block SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head word.
REQ-009 The block SHALL have port err_parity, output, 1 bit: one-cycle pulse when a check symbol mismatches.
REQ-010 The block SHALL have port err_chan, output, 1 bit: one-cycle pulse when the header symbol is 2'b11.
REQ-011 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a valid frame is dropped because the FIFO is full.
REQ-012 The block SHALL have port frame_cnt, output, 16 bits: count of valid frames written to the FIFO; wraps 0xFFFF->0.
REQ-013 The block SHALL have port err_cnt, output, 8 bits: count of error and overflow events; saturates at 0xFF.

Function
REQ-014 Frame format SHALL be 11 symbols: start 2'b11, header (channel 00/01/10), 8 data symbols MSB-first, check symbol = XOR of header and all 8 data symbols; idle line = 2'b00.
REQ-015 The FSM SHALL have states IDLE, HDR, DATA, CHECK, and rx_line SHALL be sampled directly with no input register.
REQ-016 In IDLE, 2'b11 -> HDR; any other symbol SHALL leave the FSM in IDLE.
REQ-017 In HDR, 00/01/10 SHALL be latched as channel -> DATA with symbol counter 0; 2'b11 SHALL pulse err_chan -> IDLE.
REQ-018 In DATA, each symbol SHALL be shifted in MSB-first, and after the 8th symbol (counter 7) -> CHECK.
REQ-019 In CHECK, a match SHALL push {chan,data} into the FIFO on that same edge; a mismatch SHALL pulse err_parity with no push; both -> IDLE.
REQ-020 The cycle after CHECK SHALL be evaluated in IDLE, so back-to-back frames with zero idle gap are received.
REQ-021 Latency: the word SHALL appear on out_data/out_valid after the clock edge that samples its check symbol, if the FIFO was empty.
REQ-022 The FIFO SHALL be show-ahead, and a pop SHALL occur on an edge where out_valid and out_ready are both high.
REQ-023 On push while full with no pop on the same edge, the word SHALL be dropped, overflow pulsed, and FIFO contents unchanged.
REQ-024 On push while full with a simultaneous pop, both SHALL succeed and there SHALL be no overflow.
REQ-025 On push and pop while empty, the word SHALL be written and out_valid SHALL be high next cycle.
REQ-026 frame_cnt SHALL increment only on a successful push, and err_cnt SHALL increment by 1 per err_parity, err_chan or overflow pulse.

Reset
REQ-027 arst low SHALL immediately force: FSM IDLE, FIFO empty, out_valid 0, out_data 0, out_chan 0, all pulses 0, frame_cnt 0, err_cnt 0.
REQ-028 Reset mid-frame SHALL discard the partial frame, and after release the next 2'b11 in IDLE SHALL start a new frame.

Verification
REQ-029 Scenario: line 11,01,10,10,01,01,01,01,10,10,01 -> out_data 0xA55A, out_chan 1, out_valid 1 next cycle, frame_cnt 1.
REQ-030 Scenario: same frame with check 2'b10 -> err_parity one pulse, out_valid stays 0, err_cnt 1.
REQ-031 Scenario: header 2'b11 -> err_chan pulse, FSM IDLE; a following correct frame is received.
REQ-032 Scenario: out_ready 0, 5 back-to-back valid frames with FIFO_DEPTH 4 -> 4 words held in order, overflow on the 5th, err_cnt 1.
REQ-033 Scenario: FIFO full, out_ready 1 on the edge of the 5th check symbol -> no overflow, the 5th word is retained.
REQ-034 Scenario: arst low after the 4th data symbol, then release and a full frame -> only the second frame is delivered, frame_cnt 1.

Source files
------------

// File: rtl/rx_deserializer.sv
// rx_deserializer: receives 11-symbol framed words from a 2-bit serial line,
// verifies the XOR check symbol and queues good words in a show-ahead FIFO.
// Frame: start 2'b11, header (channel), 8 data symbols MSB-first, check.
module rx_deserializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [1:0]  rx_line,
    output logic [15:0] out_data,
    output logic [1:0]  out_chan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_parity,
    output logic        err_chan,
    output logic        overflow,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_DATA  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [1:0]    r_chan;
    logic [15:0]   r_shift;
    logic [2:0]    r_sym_cnt;
    logic [1:0]    r_chk;

    logic          w_frame_ok;
    logic          w_bad_par;
    logic          w_bad_chan;

    logic [17:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_ovf;

    logic          r_err_parity;
    logic          r_err_chan;
    logic          r_overflow;
    logic [15:0]   r_frame_cnt;
    logic [7:0]    r_err_cnt;

    // Running XOR of the symbol with the accumulated check value.
    function automatic logic [1:0] chk_update(input logic [1:0] acc, input logic [1:0] sym);
        return acc ^ sym;
    endfunction

    // FSM state register; the line is sampled directly, no input flop.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-frame verdicts.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        w_bad_par   = 1'b0;
        w_bad_chan  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_line == 2'b11) begin
                    w_state_nxt = S_HDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HDR: begin
                if (rx_line == 2'b11) begin
                    w_bad_chan  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_sym_cnt == 3'd7) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CHECK: begin
                // Returning to IDLE lets a start symbol arrive the very next cycle.
                w_state_nxt = S_IDLE;
                if (rx_line == r_chk) begin
                    w_frame_ok = 1'b1;
                end else begin
                    w_bad_par = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame datapath: channel latch, data shifter, symbol counter, check accumulator.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_chan    <= 2'b00;
            r_shift   <= 16'h0000;
            r_sym_cnt <= 3'd0;
            r_chk     <= 2'b00;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (rx_line != 2'b11) begin
                        r_chan    <= rx_line;
                        r_chk     <= rx_line;
                        r_sym_cnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    r_shift   <= {r_shift[13:0], rx_line};
                    r_chk     <= chk_update(r_chk, rx_line);
                    r_sym_cnt <= r_sym_cnt + 3'd1;
                end
                default: begin
                    r_sym_cnt <= r_sym_cnt;
                end
            endcase
        end
    end

    // FIFO control: a pop frees a slot on the same edge, so full+pop still accepts.
    always_comb begin
        w_pop  = r_valid & out_ready;
        w_full = (r_count == DEPTH_C);
        w_wr   = w_frame_ok & (~w_full | w_pop);
        w_ovf  = w_frame_ok & w_full & ~w_pop;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage and pointers; out_valid is kept as its own flop.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 18'h00000;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {r_chan, r_shift};
                r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Event pulses and statistics counters (events are mutually exclusive per cycle).
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_err_parity <= 1'b0;
            r_err_chan   <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_cnt  <= 16'h0000;
            r_err_cnt    <= 8'h00;
        end else begin
            r_err_parity <= w_bad_par;
            r_err_chan   <= w_bad_chan;
            r_overflow   <= w_ovf;
            if (w_wr) begin
                r_frame_cnt <= r_frame_cnt + 16'h0001;
            end
            if ((w_bad_par | w_bad_chan | w_ovf) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
        end
    end

    assign out_data   = r_mem[r_rd_ptr][15:0];
    assign out_chan   = r_mem[r_rd_ptr][17:16];
    assign out_valid  = r_valid;
    assign err_parity = r_err_parity;
    assign err_chan   = r_err_chan;
    assign overflow   = r_overflow;
    assign frame_cnt  = r_frame_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_rx_deserializer.sv
// Testbench for rx_deserializer: scoreboard of expected {chan,data} words,
// popped and compared whenever the DUT hands a word to the consumer.
module tb_rx_deserializer;

    logic        clk;
    logic        arst;
    logic [1:0]  rx_line;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic        err_parity;
    logic        err_chan;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int          n_checks;
    int          n_pass;
    logic [17:0] exp_q [$];
    int          exp_frames;
    int          exp_errs;

    rx_deserializer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .arst       (arst),
        .rx_line    (rx_line),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_parity (err_parity),
        .err_chan   (err_chan),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Bench-side check symbol: XOR of header and all 8 data symbols.
    function automatic logic [1:0] calc_chk(input logic [1:0] ch, input logic [15:0] d);
        logic [1:0] x;
        x = ch;
        for (int i = 0; i < 8; i++) begin
            x = x ^ d[15 - 2*i -: 2];
        end
        return x;
    endfunction

    task automatic send_sym(input logic [1:0] s);
        rx_line = s;
        @(posedge clk);
        #1;
    endtask

    // Full frame; optionally raise out_ready together with the check symbol.
    task automatic send_frame(input logic [1:0] ch, input logic [15:0] d,
                              input logic [1:0] chk, input logic rdy_at_chk);
        send_sym(2'b11);
        send_sym(ch);
        for (int i = 0; i < 8; i++) begin
            send_sym(d[15 - 2*i -: 2]);
        end
        if (rdy_at_chk) begin
            out_ready = 1'b1;
        end
        send_sym(chk);
        rx_line = 2'b00;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("drain_valid", {31'd0, out_valid}, 0);
    endtask

    // Scoreboard consumer: the pop happens on the next rising edge.
    always @(negedge clk) begin
        if (arst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", {14'd0, out_chan, out_data}, 32'h3FFFF);
            end else begin
                check_eq("word", {14'd0, out_chan, out_data}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    // Overall time limit.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        logic [1:0]  ch;
        n_checks   = 0;
        n_pass     = 0;
        exp_frames = 0;
        exp_errs   = 0;
        arst       = 1'b0;
        rx_line    = 2'b00;
        out_ready  = 1'b1;
        #2;
        // Reset state.
        check_eq("rst_valid", {31'd0, out_valid}, 0);
        check_eq("rst_data", {16'd0, out_data}, 0);
        check_eq("rst_chan", {30'd0, out_chan}, 0);
        check_eq("rst_pulses", {29'd0, err_parity, err_chan, overflow}, 0);
        check_eq("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        check_eq("rst_err_cnt", {24'd0, err_cnt}, 0);
        @(posedge clk);
        #1;
        arst = 1'b1;
        send_sym(2'b00);
        send_sym(2'b01);

        // Known frame 0xA55A on channel 1.
        exp_q.push_back({2'b01, 16'hA55A});
        exp_frames++;
        send_frame(2'b01, 16'hA55A, 2'b01, 1'b0);
        check_eq("a55a_valid", {31'd0, out_valid}, 1);
        check_eq("a55a_data", {16'd0, out_data}, 32'hA55A);
        check_eq("a55a_chan", {30'd0, out_chan}, 1);
        check_eq("a55a_frame_cnt", {16'd0, frame_cnt}, exp_frames);
        drain();

        // Same frame with a wrong check symbol.
        send_frame(2'b01, 16'hA55A, 2'b10, 1'b0);
        exp_errs++;
        check_eq("par_pulse", {31'd0, err_parity}, 1);
        check_eq("par_valid", {31'd0, out_valid}, 0);
        check_eq("par_err_cnt", {24'd0, err_cnt}, exp_errs);
        send_sym(2'b00);
        check_eq("par_pulse_end", {31'd0, err_parity}, 0);
        check_eq("par_frame_cnt", {16'd0, frame_cnt}, exp_frames);

        // Illegal header, then a good frame on channel 2.
        send_sym(2'b11);
        send_sym(2'b11);
        rx_line = 2'b00;
        exp_errs++;
        check_eq("chan_pulse", {31'd0, err_chan}, 1);
        check_eq("chan_err_cnt", {24'd0, err_cnt}, exp_errs);
        send_sym(2'b00);
        check_eq("chan_pulse_end", {31'd0, err_chan}, 0);
        d = 16'h3C96;
        exp_q.push_back({2'b10, d});
        exp_frames++;
        send_frame(2'b10, d, calc_chk(2'b10, d), 1'b0);
        drain();
        check_eq("chan_frame_cnt", {16'd0, frame_cnt}, exp_frames);

        // Five back-to-back frames into a depth-4 FIFO with no consumer.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d  = 16'($urandom);
            ch = 2'(k % 3);
            if (k < 4) begin
                exp_q.push_back({ch, d});
                exp_frames++;
            end
            send_frame(ch, d, calc_chk(ch, d), 1'b0);
        end
        exp_errs++;
        check_eq("ovf_pulse", {31'd0, overflow}, 1);
        check_eq("ovf_err_cnt", {24'd0, err_cnt}, exp_errs);
        check_eq("ovf_frame_cnt", {16'd0, frame_cnt}, exp_frames);
        check_eq("ovf_full_valid", {31'd0, out_valid}, 1);
        send_sym(2'b00);
        check_eq("ovf_pulse_end", {31'd0, overflow}, 0);
        drain();

        // Full FIFO with a pop on the same edge as the fifth check symbol.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d  = 16'($urandom);
            ch = 2'((k + 1) % 3);
            exp_q.push_back({ch, d});
            exp_frames++;
            send_frame(ch, d, calc_chk(ch, d), (k == 4) ? 1'b1 : 1'b0);
        end
        check_eq("simul_no_ovf", {31'd0, overflow}, 0);
        check_eq("simul_err_cnt", {24'd0, err_cnt}, exp_errs);
        check_eq("simul_frame_cnt", {16'd0, frame_cnt}, exp_frames);
        drain();

        // Reset after the 4th data symbol of a frame.
        send_sym(2'b11);
        send_sym(2'b00);
        for (int i = 0; i < 4; i++) begin
            send_sym(2'b10);
        end
        arst = 1'b0;
        #1;
        exp_frames = 0;
        exp_errs   = 0;
        check_eq("arst_valid", {31'd0, out_valid}, 0);
        check_eq("arst_frame_cnt", {16'd0, frame_cnt}, 0);
        check_eq("arst_err_cnt", {24'd0, err_cnt}, 0);
        send_sym(2'b10);
        arst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_sym(2'b10);
        end
        send_sym(2'b00);
        check_eq("arst_no_word", {31'd0, out_valid}, 0);
        d = 16'h1234;
        exp_q.push_back({2'b00, d});
        exp_frames++;
        send_frame(2'b00, d, calc_chk(2'b00, d), 1'b0);
        drain();
        check_eq("arst_frame_cnt2", {16'd0, frame_cnt}, exp_frames);
        check_eq("arst_err_cnt2", {24'd0, err_cnt}, exp_errs);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
